jtag_dr_bank: RTL and testbench

JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

---
 rtl/jtag_pkg.sv | 61 ++++++
 rtl/jtag_axi_req_ctrl.sv | 87 ++++++++
 rtl/jtag_dr_bank.sv | 193 +++++++++++++++++++
 tb/tb_jtag_dr_bank.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_pkg
// Brief    : Shared TAP-state, instruction-decode and AXI management types for
//            the JTAG data-register bank.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_ctrl_fsm_t;

    typedef enum logic [2:0] {
        BYPASS_REGISTER     = 3'd0,
        IDCODE_REGISTER     = 3'd1,
        IC_RESET_REGISTER   = 3'd2,
        ADDR_AXI_REGISTER   = 3'd3,
        DATA_AXI_REGISTER   = 3'd4,
        MGMT_AXI_REGISTER   = 3'd5,
        STATUS_AXI_REGISTER = 3'd6
    } ir_decoding_t;

    typedef struct packed {
        logic [2:0] size;
        logic       auto_inc;
        logic       write;
        logic       start;
    } s_axi_jtag_mgmt_t;

    localparam int MGMT_WIDTH   = $bits(s_axi_jtag_mgmt_t);
    localparam int STATUS_WIDTH = 5;

    function automatic int f_dr_max_width(input int addr_w, input int data_w, input int ic_w);
        int w;
        w = 32;
        if (addr_w > w) w = addr_w;
        if (data_w > w) w = data_w;
        if (ic_w > w)   w = ic_w;
        return w;
    endfunction

    localparam int DR_MAX_WIDTH = f_dr_max_width(32, 32, 4);

endpackage
`default_nettype wire

// File: rtl/jtag_axi_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_axi_req_ctrl
// Brief    : AXI request pulse, busy check, address auto-increment and sticky
//            overflow/rvalid tracking (sticky bits only with JTAG_DR_STATUS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module jtag_axi_req_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_trig_mgmt,
    input  logic              i_trig_data,
    input  logic              i_addr_load,
    input  logic [ADDR_W-1:0] i_addr_val,
    input  logic [2:0]        i_size,
    input  logic              i_axi_busy,
    input  logic              i_axi_rvalid,
    input  logic              i_status_clr,
    output logic [ADDR_W-1:0] o_axi_addr,
    output logic              o_axi_req,
    output logic              o_overflow,
    output logic              o_rvalid_pending
);

    localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              w_trig;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic              r_inc;

    assign w_trig = i_trig_mgmt | i_trig_data;
    assign w_step = c_ONE << i_size;

    // The address advances one cycle after the pulse so the request sees the old address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_req  <= 1'b0;
            r_inc  <= 1'b0;
        end else begin
            r_req <= w_trig & ~i_axi_busy;
            r_inc <= i_trig_data & ~i_axi_busy;
            if (i_addr_load)
                r_addr <= i_addr_val;
            else if (r_inc)
                r_addr <= r_addr + w_step;
        end
    end

`ifdef JTAG_DR_STATUS_EN
    logic r_overflow;
    logic r_rvalid_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow       <= 1'b0;
            r_rvalid_pending <= 1'b0;
        end else begin
            if (w_trig && i_axi_busy)
                r_overflow <= 1'b1;
            else if (i_status_clr)
                r_overflow <= 1'b0;
            if (i_axi_rvalid)
                r_rvalid_pending <= 1'b1;
            else if (i_status_clr)
                r_rvalid_pending <= 1'b0;
        end
    end

    assign o_overflow       = r_overflow;
    assign o_rvalid_pending = r_rvalid_pending;
`else
    logic w_unused_sticky;
    assign w_unused_sticky  = &{1'b0, i_axi_rvalid, i_status_clr};
    assign o_overflow       = 1'b0;
    assign o_rvalid_pending = 1'b0;
`endif

    assign o_axi_addr = r_addr;
    assign o_axi_req  = r_req;

endmodule
`default_nettype wire

// File: rtl/jtag_dr_bank.sv
`default_nettype none
// ============================================================================
// Module   : jtag_dr_bank
// Brief    : JTAG data-register bank (BYPASS/IDCODE/IC_RESET/AXI ADDR/DATA/MGMT)
//            sharing one shift register; STATUS register with JTAG_DR_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_dr_bank
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL   = 32'h10F,
    parameter int          IC_RST_WIDTH = 4,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32
) (
    input  logic                    tck,
    input  logic                    trst,
    input  logic                    tdi,
    output logic                    tdo,
    output logic                    tdo_en,
    input  tap_ctrl_fsm_t           tap_state,
    input  ir_decoding_t            ir_dec,
    output logic [IC_RST_WIDTH-1:0] ic_rst,
    output logic [ADDR_W-1:0]       axi_addr,
    output logic [DATA_W-1:0]       axi_wdata,
    output s_axi_jtag_mgmt_t        axi_mgmt,
    output logic                    axi_req,
    input  logic                    axi_busy,
    input  logic                    axi_rvalid,
    input  logic [DATA_W-1:0]       axi_rdata,
    input  logic [1:0]              axi_status
);

    localparam int                c_DR_W = f_dr_max_width(ADDR_W, DATA_W, IC_RST_WIDTH);
    localparam logic [c_DR_W-1:0] c_ONE  = {{(c_DR_W-1){1'b0}}, 1'b1};

    generate
        if (IC_RST_WIDTH > c_DR_W || IC_RST_WIDTH < 1 ||
            !(ADDR_W == 32 || ADDR_W == 64) || !(DATA_W == 32 || DATA_W == 64)) begin : g_bad_params
            $error("jtag_dr_bank: unsupported IC_RST_WIDTH/ADDR_W/DATA_W");
        end
    endgenerate

    ir_decoding_t          w_sel;
    int                    w_len;
    logic [c_DR_W-1:0]     w_cap;
    logic [c_DR_W-1:0]     w_top;
    logic [c_DR_W-1:0]     w_mask;
    logic [c_DR_W-1:0]     w_shift;
    logic                  w_upd;
    logic                  w_overflow;
    logic                  w_rvalid_pending;

    logic [c_DR_W-1:0]       r_sr;
    logic [IC_RST_WIDTH-1:0] r_ic_rst;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata_q;
    s_axi_jtag_mgmt_t        r_mgmt;
    logic                    r_rst_q;
    logic                    r_tdo;
    logic                    r_tdo_en;

    // Anything not explicitly decoded collapses onto the 1-bit bypass path.
    always_comb begin
        w_sel = BYPASS_REGISTER;
        case (ir_dec)
            IDCODE_REGISTER, IC_RESET_REGISTER, ADDR_AXI_REGISTER,
            DATA_AXI_REGISTER, MGMT_AXI_REGISTER: w_sel = ir_dec;
`ifdef JTAG_DR_STATUS_EN
            STATUS_AXI_REGISTER:                  w_sel = ir_dec;
`endif
            default:                              w_sel = BYPASS_REGISTER;
        endcase
    end

    always_comb begin
        w_len = 1;
        w_cap = '0;
        case (w_sel)
            IDCODE_REGISTER: begin
                w_len       = 32;
                w_cap[31:0] = IDCODE_VAL;
            end
            IC_RESET_REGISTER: begin
                w_len                   = IC_RST_WIDTH;
                w_cap[IC_RST_WIDTH-1:0] = r_ic_rst;
            end
            ADDR_AXI_REGISTER: begin
                w_len             = ADDR_W;
                w_cap[ADDR_W-1:0] = axi_addr;
            end
            DATA_AXI_REGISTER: begin
                w_len             = DATA_W;
                w_cap[DATA_W-1:0] = axi_rvalid ? axi_rdata : r_rdata_q;
            end
            MGMT_AXI_REGISTER: begin
                w_len                 = MGMT_WIDTH;
                w_cap[MGMT_WIDTH-1:0] = r_mgmt;
            end
`ifdef JTAG_DR_STATUS_EN
            STATUS_AXI_REGISTER: begin
                w_len                   = STATUS_WIDTH;
                w_cap[STATUS_WIDTH-1:0] = {w_overflow, w_rvalid_pending, axi_busy, axi_status};
            end
`endif
            default: ;
        endcase
    end

    // Bits above the selected length stay zero, so tdi always lands at bit len-1.
    assign w_top   = c_ONE << (w_len - 1);
    assign w_mask  = (w_top << 1) - c_ONE;
    assign w_shift = ((r_sr >> 1) & w_mask) | (tdi ? w_top : '0);
    assign w_upd   = (tap_state == UPDATE_DR);

    always_ff @(posedge tck) begin
        if (trst || tap_state == TEST_LOGIC_RESET)
            r_sr <= '0;
        else if (tap_state == CAPTURE_DR)
            r_sr <= w_cap;
        else if (tap_state == SHIFT_DR)
            r_sr <= w_shift;
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            r_ic_rst  <= '0;
            r_wdata   <= '0;
            r_rdata_q <= '0;
            r_mgmt    <= '0;
        end else begin
            if (axi_rvalid)
                r_rdata_q <= axi_rdata;
            if (tap_state == TEST_LOGIC_RESET) begin
                r_mgmt.start <= 1'b0;
            end else if (w_upd) begin
                case (w_sel)
                    IC_RESET_REGISTER: r_ic_rst <= r_sr[IC_RST_WIDTH-1:0];
                    DATA_AXI_REGISTER: r_wdata  <= r_sr[DATA_W-1:0];
                    MGMT_AXI_REGISTER: r_mgmt   <= s_axi_jtag_mgmt_t'(r_sr[MGMT_WIDTH-1:0]);
                    default: ;
                endcase
            end
        end
    end

    jtag_axi_req_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_req_ctrl (
        .clk              (tck),
        .rst              (trst),
        .i_trig_mgmt      (w_upd && w_sel == MGMT_AXI_REGISTER && r_sr[0]),
        .i_trig_data      (w_upd && w_sel == DATA_AXI_REGISTER && r_mgmt.auto_inc),
        .i_addr_load      (w_upd && w_sel == ADDR_AXI_REGISTER),
        .i_addr_val       (r_sr[ADDR_W-1:0]),
        .i_size           (r_mgmt.size),
        .i_axi_busy       (axi_busy),
        .i_axi_rvalid     (axi_rvalid),
        .i_status_clr     (w_upd && w_sel == STATUS_AXI_REGISTER),
        .o_axi_addr       (axi_addr),
        .o_axi_req        (axi_req),
        .o_overflow       (w_overflow),
        .o_rvalid_pending (w_rvalid_pending)
    );

`ifndef JTAG_DR_STATUS_EN
    logic w_unused_status;
    assign w_unused_status = &{1'b0, w_overflow, w_rvalid_pending, axi_status};
`endif

    // Reset is registered on the rising edge so the falling-edge outputs clear one half-cycle later.
    always_ff @(posedge tck) begin
        r_rst_q <= trst;
    end

    always_ff @(negedge tck) begin
        if (r_rst_q) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= (tap_state == SHIFT_DR);
            r_tdo    <= (tap_state == SHIFT_DR) ? r_sr[0] : 1'b0;
        end
    end

    assign tdo       = r_tdo;
    assign tdo_en    = r_tdo_en;
    assign ic_rst    = r_ic_rst;
    assign axi_wdata = r_wdata;
    assign axi_mgmt  = r_mgmt;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_dr_bank
// Brief    : Directed self-checking bench for jtag_dr_bank (both STATUS builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_dr_bank;
    import jtag_pkg::*;

    logic             tck = 1'b0;
    logic             trst;
    logic             tdi;
    logic             tdo;
    logic             tdo_en;
    tap_ctrl_fsm_t    tap_state;
    ir_decoding_t     ir_dec;
    logic [3:0]       ic_rst;
    logic [31:0]      axi_addr;
    logic [31:0]      axi_wdata;
    s_axi_jtag_mgmt_t axi_mgmt;
    logic             axi_req;
    logic             axi_busy;
    logic             axi_rvalid;
    logic [31:0]      axi_rdata;
    logic [1:0]       axi_status;

    int n_pass  = 0;
    int n_total = 0;
    int n_req   = 0;
    int n_en    = 0;

    always #5 tck = ~tck;

    jtag_dr_bank dut (
        .tck        (tck),
        .trst       (trst),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .tap_state  (tap_state),
        .ir_dec     (ir_dec),
        .ic_rst     (ic_rst),
        .axi_addr   (axi_addr),
        .axi_wdata  (axi_wdata),
        .axi_mgmt   (axi_mgmt),
        .axi_req    (axi_req),
        .axi_busy   (axi_busy),
        .axi_rvalid (axi_rvalid),
        .axi_rdata  (axi_rdata),
        .axi_status (axi_status)
    );

    // axi_req changes on the rising edge, tdo_en on the falling edge; count each on the other edge.
    always @(negedge tck) if (axi_req) n_req++;
    always @(posedge tck) if (tdo_en)  n_en++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic dr_scan(input ir_decoding_t sel, input int n, input logic [63:0] din,
                           input bit upd, input bit cap_rv, output logic [63:0] dout);
        logic [63:0] d;
        d          = din;
        dout       = '0;
        ir_dec     = sel;
        axi_rvalid = cap_rv;
        tap_state  = CAPTURE_DR;
        tick();
        axi_rvalid = 1'b0;
        tap_state  = SHIFT_DR;
        for (int i = 0; i < n; i++) begin
            tdi = d[0];
            d   = d >> 1;
            @(negedge tck);
            #1;
            dout = dout | (64'(tdo) << i);
            tick();
        end
        tdi       = 1'b0;
        tap_state = EXIT1_DR;
        tick();
        if (upd) begin
            tap_state = UPDATE_DR;
            tick();
        end
        tap_state = RUN_TEST_IDLE;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dout;
        int          r0;
        int          e0;

        trst = 1'b1; tdi = 1'b0; tap_state = TEST_LOGIC_RESET; ir_dec = BYPASS_REGISTER;
        axi_busy = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_status = 2'b01;
        tick();
        tick();
        @(negedge tck);
        #1;
        check("rst_tdo",    64'(tdo),       64'h0);
        check("rst_tdo_en", 64'(tdo_en),    64'h0);
        check("rst_ic_rst", 64'(ic_rst),    64'h0);
        check("rst_addr",   64'(axi_addr),  64'h0);
        check("rst_wdata",  64'(axi_wdata), 64'h0);
        check("rst_mgmt",   64'(axi_mgmt),  64'h0);
        check("rst_req",    64'(axi_req),   64'h0);
        trst = 1'b0;
        tap_state = RUN_TEST_IDLE;
        tick();

        // IDCODE read-out
        e0 = n_en;
        dr_scan(IDCODE_REGISTER, 32, 64'h0, 1'b1, 1'b0, dout);
        check("idcode_out", dout, 64'h10F);
        check("idcode_en_edges", 64'(n_en - e0), 64'd32);
        check("idcode_en_after", 64'(tdo_en), 64'h0);

        // Bypass and undecoded instruction: one-bit delay, captured 0
        dr_scan(BYPASS_REGISTER, 4, 64'hB, 1'b1, 1'b0, dout);
        check("bypass_out", dout, 64'h6);
        dr_scan(ir_decoding_t'(3'd7), 4, 64'hB, 1'b1, 1'b0, dout);
        check("unknown_ir_out", dout, 64'h6);

        // IC_RESET write
        dr_scan(IC_RESET_REGISTER, 4, 64'hA, 1'b1, 1'b0, dout);
        check("icr_write", 64'(ic_rst), 64'hA);

        // ADDR, MGMT {size=2, auto_inc=1, write=1, start=0}, three DATA writes
        dr_scan(ADDR_AXI_REGISTER, 32, 64'h1000, 1'b1, 1'b0, dout);
        check("addr_write", 64'(axi_addr), 64'h1000);
        dr_scan(MGMT_AXI_REGISTER, 6, 64'h16, 1'b1, 1'b0, dout);
        check("mgmt_write", 64'(axi_mgmt), 64'h16);
        check("mgmt_no_req", 64'(axi_req), 64'h0);
        r0 = n_req;
        dr_scan(DATA_AXI_REGISTER, 32, 64'h11111111, 1'b1, 1'b0, dout);
        check("data1_req", 64'(axi_req), 64'h1);
        check("data1_addr_at_req", 64'(axi_addr), 64'h1000);
        tick();
        check("data1_req_fall", 64'(axi_req), 64'h0);
        check("data1_addr_inc", 64'(axi_addr), 64'h1004);
        dr_scan(DATA_AXI_REGISTER, 32, 64'h22222222, 1'b1, 1'b0, dout);
        check("data_cap_is_rdata", dout, 64'h0);
        dr_scan(DATA_AXI_REGISTER, 32, 64'h33333333, 1'b1, 1'b0, dout);
        tick();
        check("data_req_count", 64'(n_req - r0), 64'd3);
        check("data_final_addr", 64'(axi_addr), 64'h100C);
        check("data_final_wdata", 64'(axi_wdata), 64'h33333333);

        // DATA update while busy: request dropped
        r0 = n_req;
        axi_busy = 1'b1;
        dr_scan(DATA_AXI_REGISTER, 32, 64'h44444444, 1'b1, 1'b0, dout);
        tick();
        axi_busy = 1'b0;
        check("busy_no_req", 64'(n_req - r0), 64'd0);
        check("busy_addr_hold", 64'(axi_addr), 64'h100C);
        check("busy_wdata", 64'(axi_wdata), 64'h44444444);

`ifdef JTAG_DR_STATUS_EN
        dr_scan(STATUS_AXI_REGISTER, 5, 64'h0, 1'b1, 1'b0, dout);
        check("status_overflow", dout, 64'h11);
        dr_scan(STATUS_AXI_REGISTER, 5, 64'h0, 1'b1, 1'b0, dout);
        check("status_cleared", dout, 64'h01);
`else
        dr_scan(STATUS_AXI_REGISTER, 4, 64'hB, 1'b1, 1'b0, dout);
        check("status_as_bypass", dout, 64'h6);
`endif

        // axi_rvalid coincident with DATA capture
        axi_rdata = 32'hDEADBEEF;
        dr_scan(DATA_AXI_REGISTER, 32, 64'h0, 1'b0, 1'b1, dout);
        check("rvalid_bypass", dout, 64'hDEADBEEF);
        axi_rdata = '0;
        tick();
        dr_scan(DATA_AXI_REGISTER, 32, 64'h0, 1'b0, 1'b0, dout);
        check("rdata_q_hold", dout, 64'hDEADBEEF);
`ifdef JTAG_DR_STATUS_EN
        dr_scan(STATUS_AXI_REGISTER, 5, 64'h0, 1'b1, 1'b0, dout);
        check("status_rvalid_pending", dout, 64'h09);
`endif

        // trst in the middle of an IC_RESET shift
        r0 = n_req;
        ir_dec = IC_RESET_REGISTER;
        tap_state = CAPTURE_DR;
        tick();
        tap_state = SHIFT_DR;
        tdi = 1'b1;
        @(negedge tck);
        #1;
        check("icr_cap_bit0", 64'(tdo), 64'h0);
        tick();
        @(negedge tck);
        #1;
        check("icr_cap_bit1", 64'(tdo), 64'h1);
        trst = 1'b1;
        tick();
        @(negedge tck);
        #1;
        check("trst_tdo", 64'(tdo), 64'h0);
        check("trst_tdo_en", 64'(tdo_en), 64'h0);
        check("trst_ic_rst", 64'(ic_rst), 64'h0);
        check("trst_req", 64'(axi_req), 64'h0);
        check("trst_addr", 64'(axi_addr), 64'h0);
        trst = 1'b0;
        tdi = 1'b0;
        tap_state = TEST_LOGIC_RESET;
        tick();
        tap_state = RUN_TEST_IDLE;
        tick();
        check("trst_no_req", 64'(n_req - r0), 64'd0);

        // TEST_LOGIC_RESET clears start only
        dr_scan(IC_RESET_REGISTER, 4, 64'h6, 1'b1, 1'b0, dout);
        dr_scan(ADDR_AXI_REGISTER, 32, 64'h20, 1'b1, 1'b0, dout);
        dr_scan(MGMT_AXI_REGISTER, 6, 64'h01, 1'b1, 1'b0, dout);
        check("start_req", 64'(axi_req), 64'h1);
        check("start_mgmt", 64'(axi_mgmt), 64'h01);
        tick();
        check("start_addr_no_inc", 64'(axi_addr), 64'h20);
        tap_state = TEST_LOGIC_RESET;
        tick();
        tap_state = RUN_TEST_IDLE;
        check("tlr_mgmt", 64'(axi_mgmt), 64'h0);
        check("tlr_ic_rst", 64'(ic_rst), 64'h6);
        check("tlr_addr", 64'(axi_addr), 64'h20);

        // Over-length shift: excess bits fall through, last 4 bits update
        dr_scan(IC_RESET_REGISTER, 6, 64'h35, 1'b1, 1'b0, dout);
        check("long_shift_out", dout, 64'h16);
        check("long_shift_ic_rst", 64'(ic_rst), 64'hD);

        // Address wrap on auto-increment
        r0 = n_req;
        dr_scan(ADDR_AXI_REGISTER, 32, 64'hFFFFFFFC, 1'b1, 1'b0, dout);
        dr_scan(MGMT_AXI_REGISTER, 6, 64'h16, 1'b1, 1'b0, dout);
        dr_scan(DATA_AXI_REGISTER, 32, 64'h55, 1'b1, 1'b0, dout);
        tick();
        check("wrap_req", 64'(n_req - r0), 64'd1);
        check("wrap_addr", 64'(axi_addr), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
